vgafb_fetch_ctl: RTL and testbench

VGAFB_FETCH_CTL -- requirements
Module: vgafb_fetch_ctl

---
 rtl/vgafb_fetch_ctl.sv | 187 ++++++++++++++++++
 tb/tb_vgafb_fetch_ctl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vgafb_fetch_ctl.sv
// vgafb_fetch_ctl: frame fetch controller for the VGA framebuffer.
// On each accepted frame-start pulse it clears the pixel FIFO, then issues
// 4-beat FML bursts from the frame base address whenever the FIFO falls below
// LOW_WATER, until nbursts bursts have been fetched.
// Optional feature: define VGAFB_FETCH_LATECOUNT_EN to count frame starts that
// arrive before the previous frame finished fetching (late_count).

module vgafb_fetch_ctl #(
  parameter int unsigned fml_depth    = 26,
  parameter int unsigned LOW_WATER    = 1024,
  parameter int unsigned CLEAR_CYCLES = 4
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 enable,
  input  logic                 vsync_req,
  input  logic [fml_depth-1:0] baseaddress,
  input  logic [17:0]          nbursts,
  input  logic [10:0]          fifo_level,
  output logic                 fifo_we,
  output logic                 fifo_clear,
  output logic [fml_depth-1:0] fml_adr,
  output logic                 fml_stb,
  input  logic                 fml_ack,
  output logic                 frame_done,
  output logic [15:0]          late_count
);

  // Only the 32-byte-aligned part of the address is stored; low bits are 0.
  localparam int unsigned AW = fml_depth - 5;
  localparam logic [3:0] ClrLast = 4'(CLEAR_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StWaitRoom,
    StReq,
    StData
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    clr_cnt_q, clr_cnt_d;
  logic [1:0]    beat_q, beat_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [17:0]   burst_q, burst_d;
  logic [17:0]   nbursts_q, nbursts_d;
  logic          pending_q, pending_d;

  logic vsync_ok;
  logic room;
  logic frame_end;
  logic start_clear;
  logic unused_base;

  assign vsync_ok    = vsync_req & enable;
  assign room        = 32'(fifo_level) < LOW_WATER;
  assign frame_end   = burst_q == nbursts_q;
  assign fml_adr     = {adr_q, 5'b0};
  assign unused_base = ^baseaddress[4:0];

  // Next-state, datapath updates and decoded outputs.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    beat_d      = beat_q;
    adr_d       = adr_q;
    burst_d     = burst_q;
    nbursts_d   = nbursts_q;
    pending_d   = pending_q;
    start_clear = 1'b0;
    fifo_we     = 1'b0;
    fifo_clear  = 1'b0;
    fml_stb     = 1'b0;
    frame_done  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (vsync_ok) start_clear = 1'b1;
      end

      StClear: begin
        fifo_clear = 1'b1;
        if (clr_cnt_q == ClrLast) begin
          state_d = StWaitRoom;
        end else begin
          clr_cnt_d = clr_cnt_q + 4'd1;
        end
      end

      StWaitRoom: begin
        // A new frame start outranks completion of the old one.
        if (!enable) begin
          state_d = StIdle;
        end else if (vsync_req) begin
          start_clear = 1'b1;
        end else if (frame_end) begin
          frame_done = 1'b1;
          state_d    = StIdle;
        end else if (room) begin
          state_d = StReq;
        end
      end

      StReq: begin
        // Strobe and address are held until acked; nothing else interrupts it.
        fml_stb = 1'b1;
        if (vsync_ok) pending_d = 1'b1;
        if (fml_ack) begin
          state_d = StData;
          beat_d  = 2'd0;
        end
      end

      StData: begin
        fifo_we = 1'b1;
        beat_d  = beat_q + 2'd1;
        if (vsync_ok) pending_d = 1'b1;
        if (beat_q == 2'd3) begin
          adr_d   = adr_q + AW'(1);
          burst_d = burst_q + 18'd1;
          if (!enable) begin
            state_d   = StIdle;
            pending_d = 1'b0;
          end else if (pending_q || vsync_req) begin
            start_clear = 1'b1;
          end else begin
            state_d = StWaitRoom;
          end
        end
      end

      default: state_d = StIdle;
    endcase

    // Frame parameters are captured only when a new frame begins.
    if (start_clear) begin
      state_d   = StClear;
      clr_cnt_d = 4'd0;
      adr_d     = baseaddress[fml_depth-1:5];
      burst_d   = 18'd0;
      nbursts_d = nbursts;
      pending_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= StIdle;
      clr_cnt_q <= 4'd0;
      beat_q    <= 2'd0;
      adr_q     <= '0;
      burst_q   <= 18'd0;
      nbursts_q <= 18'd0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      beat_q    <= beat_d;
      adr_q     <= adr_d;
      burst_q   <= burst_d;
      nbursts_q <= nbursts_d;
      pending_q <= pending_d;
    end
  end

`ifdef VGAFB_FETCH_LATECOUNT_EN
  logic        late_evt;
  logic [15:0] late_q;

  assign late_evt = vsync_ok &
                    ((state_q == StWaitRoom) | (state_q == StReq) | (state_q == StData));
  assign late_count = late_q;

  // Saturating count of frame starts that pre-empt an unfinished frame.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      late_q <= 16'd0;
    end else if (late_evt && (late_q != 16'hFFFF)) begin
      late_q <= late_q + 16'd1;
    end
  end
`else
  assign late_count = 16'd0;
`endif

endmodule

// File: tb/tb_vgafb_fetch_ctl.sv
// Directed bench for vgafb_fetch_ctl: frame fetch, low-water gating, late
// frame start, enable drop, mid-burst reset, address wrap and empty frames.

module tb_vgafb_fetch_ctl;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        enable = 1'b0;
  logic        vsync_req = 1'b0;
  logic [25:0] baseaddress = '0;
  logic [17:0] nbursts = '0;
  logic [10:0] fifo_level = '0;
  logic        fml_ack = 1'b0;
  logic        fifo_we, fifo_clear, fml_stb, frame_done;
  logic [25:0] fml_adr;
  logic [15:0] late_count;

  int checks = 0;
  int failures = 0;
  int ack_delay = 2;
  int clr_cnt, we_cnt, fd_cnt, overlap, unstable, stb_age, we_at_clear;
  logic [25:0] adrs[$];
  logic        stb_prev = 1'b0;
  logic [25:0] adr_prev = '0;
  bit          ok;
  logic [15:0] exp_late;

  always #5 sys_clk = ~sys_clk;

  vgafb_fetch_ctl dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .enable      (enable),
    .vsync_req   (vsync_req),
    .baseaddress (baseaddress),
    .nbursts     (nbursts),
    .fifo_level  (fifo_level),
    .fifo_we     (fifo_we),
    .fifo_clear  (fifo_clear),
    .fml_adr     (fml_adr),
    .fml_stb     (fml_stb),
    .fml_ack     (fml_ack),
    .frame_done  (frame_done),
    .late_count  (late_count)
  );

  // Mid-cycle monitor plus FML slave acking ack_delay cycles after strobe rises.
  always @(negedge sys_clk) begin
    if (fifo_clear) begin
      clr_cnt++;
      if (we_cnt > 0 && we_at_clear < 0) we_at_clear = we_cnt;
    end
    if (fifo_we) we_cnt++;
    if (frame_done) fd_cnt++;
    if (fifo_we && fifo_clear) overlap++;
    if (fml_stb && !stb_prev) adrs.push_back(fml_adr);
    if (fml_stb && stb_prev && fml_adr !== adr_prev) unstable++;
    stb_prev = fml_stb;
    adr_prev = fml_adr;
    if (fml_stb && !sys_rst) begin
      fml_ack = (stb_age == ack_delay);
      stb_age++;
    end else begin
      fml_ack = 1'b0;
      stb_age = 0;
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic clear_counts();
    clr_cnt = 0; we_cnt = 0; fd_cnt = 0; overlap = 0; unstable = 0; we_at_clear = -1;
    adrs.delete();
  endtask

  task automatic do_reset();
    sys_rst = 1'b1; enable = 1'b0; vsync_req = 1'b0; fifo_level = '0;
    baseaddress = '0; nbursts = '0;
    repeat (2) tick();
    sys_rst = 1'b0;
    tick();
    clear_counts();
  endtask

  task automatic pulse_vsync();
    vsync_req = 1'b1;
    tick();
    vsync_req = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit done);
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (fd_cnt > 0) begin
        done = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_stb(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge sys_clk);
      if (fml_stb) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; enable = 1'b1; vsync_req = 1'b1; nbursts = 18'd1;
    repeat (2) tick();
    vsync_req = 1'b0;
    checks++; if (fml_stb !== 1'b0) begin failures++; $display("FAIL rst_stb got %b want 0", fml_stb); end
    checks++; if (fifo_we !== 1'b0) begin failures++; $display("FAIL rst_we got %b want 0", fifo_we); end
    checks++; if (fifo_clear !== 1'b0) begin failures++; $display("FAIL rst_clear got %b want 0", fifo_clear); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL rst_done got %b want 0", frame_done); end
    checks++; if (fml_adr !== 26'h0) begin failures++; $display("FAIL rst_adr got %h want 0", fml_adr); end
    checks++; if (late_count !== 16'h0) begin failures++; $display("FAIL rst_late got %h want 0", late_count); end
  endtask

  task automatic test_frame();
    do_reset();
    ack_delay = 2; baseaddress = 26'h100040; nbursts = 18'd3; enable = 1'b1;
    pulse_vsync();
    baseaddress = 26'h0001000; nbursts = 18'd7;  // must not affect the running frame
    wait_done(300, ok);
    repeat (10) tick();
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL frame_timeout got %b want 1", ok); end
    checks++; if (clr_cnt != 4) begin failures++; $display("FAIL frame_clear got %0d want 4", clr_cnt); end
    checks++; if (we_cnt != 12) begin failures++; $display("FAIL frame_we got %0d want 12", we_cnt); end
    checks++; if (fd_cnt != 1) begin failures++; $display("FAIL frame_done got %0d want 1", fd_cnt); end
    checks++; if (adrs.size() != 3) begin failures++; $display("FAIL frame_nbursts got %0d want 3", adrs.size()); end
    if (adrs.size() > 2) begin
      checks++; if (adrs[0] !== 26'h100040) begin failures++; $display("FAIL frame_adr0 got %h want 100040", adrs[0]); end
      checks++; if (adrs[1] !== 26'h100060) begin failures++; $display("FAIL frame_adr1 got %h want 100060", adrs[1]); end
      checks++; if (adrs[2] !== 26'h100080) begin failures++; $display("FAIL frame_adr2 got %h want 100080", adrs[2]); end
    end
    checks++; if (overlap != 0) begin failures++; $display("FAIL frame_overlap got %0d want 0", overlap); end
    checks++; if (unstable != 0) begin failures++; $display("FAIL frame_stb_stable got %0d want 0", unstable); end
  endtask

  task automatic test_low_water();
    do_reset();
    ack_delay = 1; nbursts = 18'd1; fifo_level = 11'd1024; enable = 1'b1;
    pulse_vsync();
    repeat (30) tick();
    checks++; if (adrs.size() != 0) begin failures++; $display("FAIL lw_held got %0d want 0", adrs.size()); end
    checks++; if (clr_cnt != 4) begin failures++; $display("FAIL lw_clear got %0d want 4", clr_cnt); end
    fifo_level = 11'd1023;
    @(negedge sys_clk);
    checks++; if (fml_stb !== 1'b0) begin failures++; $display("FAIL lw_same_cycle got %b want 0", fml_stb); end
    @(negedge sys_clk);
    checks++; if (fml_stb !== 1'b1) begin failures++; $display("FAIL lw_next_cycle got %b want 1", fml_stb); end
    wait_done(100, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL lw_timeout got %b want 1", ok); end
    checks++; if (we_cnt != 4) begin failures++; $display("FAIL lw_we got %0d want 4", we_cnt); end
    checks++; if (adrs.size() != 1) begin failures++; $display("FAIL lw_bursts got %0d want 1", adrs.size()); end
  endtask

  task automatic test_late_vsync();
    do_reset();
    ack_delay = 10; baseaddress = 26'h200000; nbursts = 18'd2; enable = 1'b1;
    pulse_vsync();
    wait_stb(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL late_stb_timeout got %b want 1", ok); end
    tick();
    pulse_vsync();
    for (int i = 0; i < 100 && we_at_clear < 0; i++) tick();
    checks++; if (we_at_clear != 4) begin failures++; $display("FAIL late_beats got %0d want 4", we_at_clear); end
    checks++; if (fd_cnt != 0) begin failures++; $display("FAIL late_no_done got %0d want 0", fd_cnt); end
    checks++; if (unstable != 0) begin failures++; $display("FAIL late_stb_stable got %0d want 0", unstable); end
    if (adrs.size() > 0) begin
      checks++; if (adrs[0] !== 26'h200000) begin failures++; $display("FAIL late_adr0 got %h want 200000", adrs[0]); end
    end
    checks++; if (late_count !== exp_late) begin failures++; $display("FAIL late_count got %0d want %0d", late_count, exp_late); end
    wait_done(300, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL late_timeout got %b want 1", ok); end
    checks++; if (we_cnt != 12) begin failures++; $display("FAIL late_total_we got %0d want 12", we_cnt); end
    checks++; if (clr_cnt != 8) begin failures++; $display("FAIL late_clears got %0d want 8", clr_cnt); end
  endtask

  task automatic test_enable_drop();
    do_reset();
    ack_delay = 5; baseaddress = 26'h300000; nbursts = 18'd3; enable = 1'b1;
    pulse_vsync();
    wait_stb(ok);
    tick();
    enable = 1'b0;
    repeat (40) tick();
    checks++; if (we_cnt != 4) begin failures++; $display("FAIL en_we got %0d want 4", we_cnt); end
    checks++; if (fd_cnt != 0) begin failures++; $display("FAIL en_done got %0d want 0", fd_cnt); end
    pulse_vsync();
    repeat (10) tick();
    checks++; if (clr_cnt != 4) begin failures++; $display("FAIL en_vsync_ignored got %0d want 4", clr_cnt); end
    enable = 1'b1;
    repeat (10) tick();
    checks++; if (adrs.size() != 1) begin failures++; $display("FAIL en_idle got %0d want 1", adrs.size()); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ack_delay = 0; baseaddress = 26'h000040; nbursts = 18'd2; enable = 1'b1;
    pulse_vsync();
    for (int i = 0; i < 60; i++) begin
      @(negedge sys_clk);
      #1;
      if (we_cnt == 2) break;
    end
    checks++; if (we_cnt != 2) begin failures++; $display("FAIL rmid_beat2 got %0d want 2", we_cnt); end
    sys_rst = 1'b1;
    #1;
    checks++; if (fifo_we !== 1'b0) begin failures++; $display("FAIL rmid_we got %b want 0", fifo_we); end
    checks++; if (fml_stb !== 1'b0) begin failures++; $display("FAIL rmid_stb got %b want 0", fml_stb); end
    checks++; if (fml_adr !== 26'h0) begin failures++; $display("FAIL rmid_adr got %h want 0", fml_adr); end
    checks++; if (fifo_clear !== 1'b0) begin failures++; $display("FAIL rmid_clear got %b want 0", fifo_clear); end
    repeat (2) tick();
    sys_rst = 1'b0;
    repeat (20) tick();
    checks++; if (we_cnt != 2) begin failures++; $display("FAIL rmid_no_more_we got %0d want 2", we_cnt); end
    checks++; if (adrs.size() != 1) begin failures++; $display("FAIL rmid_idle got %0d want 1", adrs.size()); end
  endtask

  task automatic test_wrap();
    do_reset();
    ack_delay = 1; baseaddress = 26'h3FFFFE0; nbursts = 18'd2; enable = 1'b1;
    pulse_vsync();
    wait_done(200, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL wrap_timeout got %b want 1", ok); end
    checks++; if (adrs.size() != 2) begin failures++; $display("FAIL wrap_bursts got %0d want 2", adrs.size()); end
    if (adrs.size() > 1) begin
      checks++; if (adrs[0] !== 26'h3FFFFE0) begin failures++; $display("FAIL wrap_adr0 got %h want 3ffffe0", adrs[0]); end
      checks++; if (adrs[1] !== 26'h0) begin failures++; $display("FAIL wrap_adr1 got %h want 0", adrs[1]); end
    end
    checks++; if (we_cnt != 8) begin failures++; $display("FAIL wrap_we got %0d want 8", we_cnt); end
  endtask

  task automatic test_zero_bursts();
    do_reset();
    nbursts = 18'd0; enable = 1'b1;
    pulse_vsync();
    wait_done(50, ok);
    repeat (5) tick();
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL zero_timeout got %b want 1", ok); end
    checks++; if (fd_cnt != 1) begin failures++; $display("FAIL zero_done got %0d want 1", fd_cnt); end
    checks++; if (adrs.size() != 0) begin failures++; $display("FAIL zero_stb got %0d want 0", adrs.size()); end
    checks++; if (clr_cnt != 4) begin failures++; $display("FAIL zero_clear got %0d want 4", clr_cnt); end
  endtask

  initial begin
`ifdef VGAFB_FETCH_LATECOUNT_EN
    exp_late = 16'd1;
`else
    exp_late = 16'd0;
`endif
    clear_counts();
    test_reset();
    test_frame();
    test_low_water();
    test_late_vsync();
    test_enable_drop();
    test_reset_mid();
    test_wrap();
    test_zero_bursts();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
